alu_seq: RTL

- Parametrised, multi-cycle integer ALU for the RV64I datapath, extended toward RV64M.
- Single-cycle ops complete with a one-cycle registered latency. MUL/DIVU/REMU run iteratively, one bit per cycle.
- A valid/ready handshake on both input and output lets the execute stage stall on long ops.
- Generates a zero flag (Z) for branch resolution and an illegal-op flag.

---
 rtl/alu_seq.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- multi-cycle integer ALU for the RV64I execute stage (RV64M subset)
//
// Single-cycle ops (AND/OR/ADD/SUB/XOR/SLL/SRL/SRA/SLT/SLTU) register their
// result on the accept edge. MUL, DIVU and REMU iterate one bit per clock:
// the result is written on the XLEN-th BUSY edge.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/op presented
//   in_ready   block can accept (high only in IDLE)
//   in1, in2   operands A / B (XLEN bits)
//   ALUop      4-bit operation select
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out        result (XLEN bits)
//   Z          1 when out == 0
//   err        1 when the captured ALUop was illegal
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int XLEN      = 64,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      ALUop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            Z,
    output logic            err
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for opcodes that complete in one cycle.
    function automatic logic is_base_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL,
            OP_SRL, OP_SUB, OP_SRA, OP_SLT, OP_SLTU: is_base_op = 1'b1;
            default:                                 is_base_op = 1'b0;
        endcase
    endfunction

    // True for the iterative multiply/divide opcodes.
    function automatic logic is_muldiv_op(input logic [3:0] op);
        case (op)
            OP_MUL, OP_DIVU, OP_REMU: is_muldiv_op = 1'b1;
            default:                  is_muldiv_op = 1'b0;
        endcase
    endfunction

    state_t            state_r, state_nx_s;
    logic [3:0]        op_r;
    logic [CW-1:0]     cnt_r;
    logic [XLEN-1:0]   a_r;      // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]   b_r;      // multiplier, or divisor
    logic [XLEN-1:0]   acc_r;    // product accumulator, or partial remainder

    logic              accept_s;
    logic              legal_s;
    logic              div0_s;
    logic              long_s;
    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   alu_res_s;
    logic [XLEN-1:0]   idle_res_s;

    logic [XLEN-1:0]   a_nx_s;
    logic [XLEN-1:0]   b_nx_s;
    logic [XLEN-1:0]   acc_nx_s;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   fin_s;
    logic              last_s;

    // Decode of the presented operation in IDLE.
    always_comb begin
        accept_s = in_valid && (state_r == ST_IDLE);
        legal_s  = is_base_op(ALUop) || (MULDIV_EN && is_muldiv_op(ALUop));
        div0_s   = MULDIV_EN && ((ALUop == OP_DIVU) || (ALUop == OP_REMU))
                   && (in2 == {XLEN{1'b0}});
        long_s   = MULDIV_EN && is_muldiv_op(ALUop) && !div0_s;
        shamt_s  = in2[SHW-1:0];
    end

    // Single-cycle function unit.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (ALUop)
            OP_AND:  alu_res_s = in1 & in2;
            OP_OR:   alu_res_s = in1 | in2;
            OP_ADD:  alu_res_s = in1 + in2;
            OP_SUB:  alu_res_s = in1 - in2;
            OP_XOR:  alu_res_s = in1 ^ in2;
            OP_SLL:  alu_res_s = in1 << shamt_s;
            OP_SRL:  alu_res_s = in1 >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(in1) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (in1 < in2)};
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Result written on the accept edge: illegal, divide-by-zero or 1-cycle op.
    always_comb begin
        if (!legal_s) begin
            idle_res_s = {XLEN{1'b0}};
        end else if (div0_s) begin
            idle_res_s = (ALUop == OP_DIVU) ? {XLEN{1'b1}} : in1;
        end else begin
            idle_res_s = alu_res_s;
        end
    end

    // One shift-add or restoring-division step on the captured operands.
    always_comb begin
        a_nx_s   = a_r;
        b_nx_s   = b_r;
        acc_nx_s = acc_r;
        // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
        rem_sh_s = {acc_r, a_r[XLEN-1]};
        diff_s   = rem_sh_s - {1'b0, b_r};
        if (op_r == OP_MUL) begin
            acc_nx_s = b_r[0] ? (acc_r + a_r) : acc_r;
            a_nx_s   = a_r << 1;
            b_nx_s   = b_r >> 1;
        end else if (!diff_s[XLEN]) begin
            acc_nx_s = diff_s[XLEN-1:0];
            a_nx_s   = {a_r[XLEN-2:0], 1'b1};
        end else begin
            acc_nx_s = rem_sh_s[XLEN-1:0];
            a_nx_s   = {a_r[XLEN-2:0], 1'b0};
        end
        case (op_r)
            OP_MUL:  fin_s = acc_nx_s;
            OP_DIVU: fin_s = a_nx_s;
            OP_REMU: fin_s = acc_nx_s;
            default: fin_s = {XLEN{1'b0}};
        endcase
        last_s = (cnt_r == LAST_CNT);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = long_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: in_ready  = 1'b1;
            ST_BUSY: in_ready  = 1'b0;
            ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand capture, iteration registers and the registered result/flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r  <= 4'b0000;
            cnt_r <= {CW{1'b0}};
            a_r   <= {XLEN{1'b0}};
            b_r   <= {XLEN{1'b0}};
            acc_r <= {XLEN{1'b0}};
            out   <= {XLEN{1'b0}};
            Z     <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r  <= ALUop;
                        cnt_r <= {CW{1'b0}};
                        a_r   <= in1;
                        b_r   <= in2;
                        acc_r <= {XLEN{1'b0}};
                        if (!long_s) begin
                            out <= idle_res_s;
                            Z   <= (idle_res_s == {XLEN{1'b0}});
                            err <= !legal_s;
                        end else begin
                            err <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    a_r   <= a_nx_s;
                    b_r   <= b_nx_s;
                    acc_r <= acc_nx_s;
                    if (last_s) begin
                        out <= fin_s;
                        Z   <= (fin_s == {XLEN{1'b0}});
                        err <= 1'b0;
                    end else begin
                        err <= err;
                    end
                end
                ST_DONE: begin
                    out <= out;
                end
                default: begin
                    out <= out;
                end
            endcase
        end
    end

endmodule
